donut_shade: RTL and testbench

//  Pixel-output stage directly downstream of the ray-marched donut renderer.
//  - Takes the renderer's per-pixel hit flag and 6-bit luma, plus the VGA timing counters/syncs.
//  - Tints the luma, composites it over a scrolling background, and ordered-dithers (4x4 Bayer)

---
 rtl/donut_shade_pkg.sv | 32 +++
 rtl/donut_shade_dither_quant.sv | 36 +++
 rtl/donut_shade.sv | 115 +++++++++++
 tb/tb_donut_shade.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/donut_shade_pkg.sv
// Shared constants and the 4x4 Bayer threshold lookup for the donut pixel-output stage.
package donut_shade_pkg;

    localparam int CHAN_W = 2;
    localparam int LUMA_W = 6;
    localparam int THR_W  = 4;

    // Row index is the vertical cell (v_count[1:0]), column is the horizontal cell.
    function automatic logic [THR_W-1:0] bayer_thr(input logic [1:0] y, input logic [1:0] x);
        logic [THR_W-1:0] t;
        case ({y, x})
            4'b00_00: t = 4'd0;
            4'b00_01: t = 4'd8;
            4'b00_10: t = 4'd2;
            4'b00_11: t = 4'd10;
            4'b01_00: t = 4'd12;
            4'b01_01: t = 4'd4;
            4'b01_10: t = 4'd14;
            4'b01_11: t = 4'd6;
            4'b10_00: t = 4'd3;
            4'b10_01: t = 4'd11;
            4'b10_10: t = 4'd1;
            4'b10_11: t = 4'd9;
            4'b11_00: t = 4'd15;
            4'b11_01: t = 4'd7;
            4'b11_10: t = 4'd13;
            default:  t = 4'd5;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/donut_shade_dither_quant.sv
// Ordered-dither quantiser: 6-bit level plus 4-bit Bayer threshold to a registered, saturated 2-bit channel.
module donut_shade_dither_quant
    import donut_shade_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [LUMA_W-1:0] level,
    input  logic [THR_W-1:0]  thr,
    output logic [CHAN_W-1:0] q
);

    logic [CHAN_W:0]   sum;
    logic [CHAN_W-1:0] q_d;
    logic [CHAN_W-1:0] q_q;

    // Round up only when the fractional nibble beats the threshold; a sum of 4 clamps to 3.
    always_comb begin
        sum = {1'b0, level[5:4]} + {2'b00, (level[3:0] > thr)};
        q_d = '0;
        if (en) begin
            q_d = sum[CHAN_W] ? 2'd3 : sum[CHAN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/donut_shade.sv
// Donut pixel-output stage: tint, scrolling background, 4x4 ordered dither to RGB222, syncs realigned to 2 clocks.
module donut_shade
    import donut_shade_pkg::*;
#(
    parameter int PIX_SHIFT = 3,
    parameter bit BG_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       h_count,
    input  logic [9:0]        v_count,
    input  logic              display_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              donut_visible,
    input  logic [LUMA_W-1:0] donut_luma,
    output logic [CHAN_W-1:0] r,
    output logic [CHAN_W-1:0] g,
    output logic [CHAN_W-1:0] b,
    output logic              hsync,
    output logic              vsync
);

    logic              frame_start;
    logic [4:0]        bg_sum;
    logic [7:0]        frame_cnt_d, frame_cnt_q;
    logic [LUMA_W-1:0] r_lvl_d, r_lvl_q;
    logic [LUMA_W-1:0] g_lvl_d, g_lvl_q;
    logic [LUMA_W-1:0] b_lvl_d, b_lvl_q;
    logic [THR_W-1:0]  thr_d, thr_q;
    logic              de_q;
    logic              hs1_q, vs1_q;
    logic              hs2_q, vs2_q;

    // Background row colour scrolls with the frame counter as it was before this clock's increment.
    always_comb begin
        frame_start = (h_count == 11'd0) && (v_count == 10'd0);
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        bg_sum = v_count[9:5] + frame_cnt_q[7:3];
        thr_d  = bayer_thr(v_count[1:0], h_count[PIX_SHIFT+1:PIX_SHIFT]);

        r_lvl_d = '0;
        g_lvl_d = '0;
        b_lvl_d = '0;
        if (donut_visible) begin
            r_lvl_d = donut_luma;
            g_lvl_d = donut_luma - (donut_luma >> 2);
            b_lvl_d = donut_luma >> 1;
        end else if (BG_ENABLE) begin
            g_lvl_d = {2'b00, bg_sum[4:1]};
            b_lvl_d = {1'b0, bg_sum};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            r_lvl_q     <= '0;
            g_lvl_q     <= '0;
            b_lvl_q     <= '0;
            thr_q       <= '0;
            de_q        <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            hs2_q       <= 1'b1;
            vs2_q       <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            r_lvl_q     <= r_lvl_d;
            g_lvl_q     <= g_lvl_d;
            b_lvl_q     <= b_lvl_d;
            thr_q       <= thr_d;
            de_q        <= display_on;
            hs1_q       <= hsync_in;
            vs1_q       <= vsync_in;
            hs2_q       <= hs1_q;
            vs2_q       <= vs1_q;
        end
    end

    donut_shade_dither_quant u_quant_r (
        .clk   (clk),
        .rst   (rst),
        .en    (de_q),
        .level (r_lvl_q),
        .thr   (thr_q),
        .q     (r)
    );

    donut_shade_dither_quant u_quant_g (
        .clk   (clk),
        .rst   (rst),
        .en    (de_q),
        .level (g_lvl_q),
        .thr   (thr_q),
        .q     (g)
    );

    donut_shade_dither_quant u_quant_b (
        .clk   (clk),
        .rst   (rst),
        .en    (de_q),
        .level (b_lvl_q),
        .thr   (thr_q),
        .q     (b)
    );

    assign hsync = hs2_q;
    assign vsync = vs2_q;

endmodule

// File: tb/tb_donut_shade.sv
// Directed self-checking bench for donut_shade: reset, dither sweeps, blanking, sync delay, background and frame counter.
module tb_donut_shade;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        display_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        donut_visible;
    logic [5:0]  donut_luma;
    logic [1:0]  r, g, b;
    logic        hsync, vsync;
    logic [1:0]  r_nb, g_nb, b_nb;
    logic        hsync_nb, vsync_nb;

    int n_checks = 0;
    int n_fail   = 0;

    int bayer [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    always #5 clk = ~clk;

    donut_shade #(.PIX_SHIFT(3), .BG_ENABLE(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .h_count       (h_count),
        .v_count       (v_count),
        .display_on    (display_on),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .donut_visible (donut_visible),
        .donut_luma    (donut_luma),
        .r             (r),
        .g             (g),
        .b             (b),
        .hsync         (hsync),
        .vsync         (vsync)
    );

    donut_shade #(.PIX_SHIFT(3), .BG_ENABLE(1'b0)) dut_nobg (
        .clk           (clk),
        .rst           (rst),
        .h_count       (h_count),
        .v_count       (v_count),
        .display_on    (display_on),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .donut_visible (donut_visible),
        .donut_luma    (donut_luma),
        .r             (r_nb),
        .g             (g_nb),
        .b             (b_nb),
        .hsync         (hsync_nb),
        .vsync         (vsync_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cell (x,y) with a nonzero h_count so no frame start fires while sweeping.
    task automatic set_cell(input int x, input int y, input int v_base);
        h_count = 11'(x * 8 + 1);
        v_count = 10'(v_base + y);
    endtask

    task automatic pulse_frame_start(input int n);
        for (int i = 0; i < n; i++) begin
            h_count = 11'd0;
            v_count = 10'd0;
            tick();
            h_count = 11'd1;
            tick();
        end
    endtask

    task automatic test_reset();
        display_on = 1'b1; donut_visible = 1'b1; donut_luma = 6'd63;
        hsync_in = 1'b0; vsync_in = 1'b0;
        set_cell(0, 0, 100);
        tick(); tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({r, g, b} !== 6'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL reset_hold%0d: rgb=%b hs=%b vs=%b, want rgb=000000 hs=1 vs=1", i, {r, g, b}, hsync, vsync);
            end
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (r !== 2'd0 || hsync !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_release1: r=%0d hs=%b, want r=0 hs=1", r, hsync);
        end
        tick();
        n_checks++;
        if (r !== 2'd3 || hsync !== 1'b0 || vsync !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release2: r=%0d hs=%b vs=%b, want r=3 hs=0 vs=0", r, hsync, vsync);
        end
        hsync_in = 1'b1; vsync_in = 1'b1;
    endtask

    task automatic test_full_luma();
        display_on = 1'b0; donut_visible = 1'b1; donut_luma = 6'd63;
        set_cell(0, 0, 0);
        tick(); tick();
        display_on = 1'b1;
        tick();
        n_checks++;
        if (r !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL latency_1clk: r=%0d, want 0", r);
        end
        tick();
        n_checks++;
        if (r !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL latency_2clk: r=%0d, want 3", r);
        end
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                set_cell(x, y, 0);
                tick(); tick();
                n_checks++;
                if (r !== 2'd3 || g !== 2'd3 || b !== ((bayer[y*4+x] == 15) ? 2'd1 : 2'd2)) begin
                    n_fail++;
                    $display("[TB] FAIL luma63_x%0d_y%0d: rgb=%0d,%0d,%0d, want 3,3,%0d", x, y, r, g, b,
                             (bayer[y*4+x] == 15) ? 1 : 2);
                end
            end
        end
    endtask

    // L=8 gives R=8, G=6, B=4: each channel rounds up only where T is below its level.
    task automatic test_low_luma();
        int t;
        display_on = 1'b1; donut_visible = 1'b1; donut_luma = 6'd8;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                t = bayer[y*4+x];
                set_cell(x, y, 0);
                tick(); tick();
                n_checks++;
                if (r !== ((t < 8) ? 2'd1 : 2'd0) || g !== ((t < 6) ? 2'd1 : 2'd0) || b !== ((t < 4) ? 2'd1 : 2'd0)) begin
                    n_fail++;
                    $display("[TB] FAIL luma8_T%0d: rgb=%0d,%0d,%0d, want %0d,%0d,%0d", t, r, g, b,
                             (t < 8) ? 1 : 0, (t < 6) ? 1 : 0, (t < 4) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_blank_sync();
        logic [11:0] hpat;
        logic [11:0] vpat;
        hpat = 12'b0110_0011_1010;
        vpat = 12'b1100_1110_0101;
        display_on = 1'b0; donut_visible = 1'b1; donut_luma = 6'd63;
        for (int x = 0; x < 4; x++) begin
            set_cell(x, 3, 0);
            tick(); tick();
            n_checks++;
            if ({r, g, b} !== 6'd0) begin
                n_fail++;
                $display("[TB] FAIL blank_x%0d: rgb=%b, want 000000", x, {r, g, b});
            end
        end
        for (int i = 0; i < 12; i++) begin
            if (i >= 2) begin
                n_checks++;
                if (hsync !== hpat[i-2] || vsync !== vpat[i-2]) begin
                    n_fail++;
                    $display("[TB] FAIL sync_delay%0d: hs=%b vs=%b, want hs=%b vs=%b", i, hsync, vsync, hpat[i-2], vpat[i-2]);
                end
            end
            hsync_in = hpat[i];
            vsync_in = vpat[i];
            tick();
        end
        hsync_in = 1'b1; vsync_in = 1'b1;
    endtask

    task automatic test_background();
        int t;
        rst = 1'b1; h_count = 11'd1; v_count = 10'd0;
        tick();
        rst = 1'b0;
        pulse_frame_start(8);
        display_on = 1'b1; donut_visible = 1'b0; donut_luma = 6'bxxxxxx;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                t = bayer[y*4+x];
                set_cell(x, y, 0);
                tick(); tick();
                n_checks++;
                if (r !== 2'd0 || g !== 2'd0 || b !== ((t == 0) ? 2'd1 : 2'd0)) begin
                    n_fail++;
                    $display("[TB] FAIL bg1_T%0d: rgb=%0d,%0d,%0d, want 0,0,%0d", t, r, g, b, (t == 0) ? 1 : 0);
                end
                n_checks++;
                if ({r_nb, g_nb, b_nb} !== 6'd0) begin
                    n_fail++;
                    $display("[TB] FAIL nobg_T%0d: rgb=%b, want 000000", t, {r_nb, g_nb, b_nb});
                end
            end
        end
        // 248 more starts brings the count to 256, which wraps to 0.
        pulse_frame_start(248);
        set_cell(0, 0, 0);
        tick(); tick();
        n_checks++;
        if (b !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL wrap256_v0: b=%0d, want 0", b);
        end
        set_cell(0, 0, 32);
        tick(); tick();
        n_checks++;
        if (b !== 2'd1 || g !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL wrap256_v32: g=%0d b=%0d, want g=0 b=1", g, b);
        end
        set_cell(0, 0, 160);
        tick(); tick();
        n_checks++;
        if (r !== 2'd0 || g !== 2'd1 || b !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL bg5_T0: rgb=%0d,%0d,%0d, want 0,1,1", r, g, b);
        end
        set_cell(2, 0, 160);
        tick(); tick();
        n_checks++;
        if (r !== 2'd0 || g !== 2'd0 || b !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL bg5_T2: rgb=%0d,%0d,%0d, want 0,0,1", r, g, b);
        end
    endtask

    task automatic test_reset_frame_start();
        display_on = 1'b1; donut_visible = 1'b0;
        pulse_frame_start(5);
        rst = 1'b1; h_count = 11'd0; v_count = 10'd0;
        tick();
        rst = 1'b0; h_count = 11'd1;
        tick();
        pulse_frame_start(7);
        set_cell(0, 0, 0);
        tick(); tick();
        n_checks++;
        if (b !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_vs_frame_cnt7: b=%0d, want 0", b);
        end
        pulse_frame_start(1);
        set_cell(0, 0, 0);
        tick(); tick();
        n_checks++;
        if (b !== 2'd1) begin
            n_fail++;
            $display("[TB] FAIL rst_vs_frame_cnt8: b=%0d, want 1", b);
        end
    endtask

    initial begin
        rst = 1'b1;
        h_count = 11'd1; v_count = 10'd0;
        display_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        donut_visible = 1'b0; donut_luma = 6'd0;
        tick(); tick();
        n_checks++;
        if ({r, g, b} !== 6'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL power_on_reset: rgb=%b hs=%b vs=%b, want rgb=000000 hs=1 vs=1", {r, g, b}, hsync, vsync);
        end
        rst = 1'b0;
        tick();

        test_reset();
        test_full_luma();
        test_low_luma();
        test_blank_sync();
        test_background();
        test_reset_frame_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
